cpu8_prog_sequencer: RTL
========================

# cpu8_prog_sequencer

Program sequencer for the 8-bit accumulator CPU. It buffers a short instruction program loaded byte-by-byte over a valid/ready port. On `start` it issues the program to the CPU's 8-bit instruction input, one instruction per clock, then pulses `done`. It sits between the host/test interface and the CPU and is the only driver of the CPU instruction bus.

## Interface
- `DEPTH`, default 16: program slots; power of two, 2..256. `AW = $clog2(DEPTH)`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  program byte offered.
- `wr_data`  in  8  instruction byte: [7:4] opcode, [3:0] operand.
- `wr_ready`  out  1  buffer accepts a byte this cycle.
- `clear`  in  1  empty the buffer (IDLE only).
- `start`  in  1  begin execution (IDLE only).
- `abort`  in  1  terminate a run.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at normal run completion.
- `prog_len`  out  AW+1  number of loaded bytes.
- `cpu_instr`  out  8  drives CPU instruction input.
- `cpu_valid`  out  1  `cpu_instr` carries a real issued instruction.
- `loop_count`  in  4  extra passes; present only with `CPU8_SEQ_LOOP_EN`.

## Operation
- States: IDLE, RUN, DONE.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, F HALT. Opcodes 6–E are issued unchanged.
- IDLE behaviour:
  - `wr_ready = (prog_len != DEPTH)`.
  - A handshake writes `wr_data` at index `prog_len` and increments `prog_len`.
  - `clear` sets `prog_len` to 0. If `clear` and a write coincide, `clear` wins and the write is dropped.
- IDLE -> RUN on `start` when `prog_len != 0`. The program counter `pc` is set to 0.
- IDLE -> DONE on `start` when `prog_len == 0`. Nothing is issued.
- A write and `start` in the same cycle: the byte is stored and is part of the program.
- RUN behaviour:
  - Each cycle the byte at `pc` is presented.
  - A non-HALT byte is driven on `cpu_instr` with `cpu_valid = 1`, and `pc` increments.
  - HALT is not issued (`cpu_instr = 8'h00`, `cpu_valid = 0`) and the state goes to DONE.
  - Issuing index `prog_len-1` sends the next state to DONE.
- DONE: `done = 1` for one cycle, then IDLE.
- `abort` in RUN: next state is IDLE. No `done`. `cpu_instr = 0` and `cpu_valid = 0` from the next cycle. `abort` has no effect outside RUN.
- In RUN and DONE, `wr_ready = 0` and `clear`/`start` are ignored.
- The buffer contents and `prog_len` survive a run, so the same program can be rerun.
- Outside issue cycles, `cpu_instr = 8'h00` (NOP) and `cpu_valid = 0`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `prog_len = 0`, `pc = 0`, `busy = 0`, `done = 0`, `cpu_instr = 8'h00`, `cpu_valid = 0`. `wr_ready = 1`, since it is derived from the reset state.
- `rst` mid-run: the run stops immediately and the buffer is emptied.
- Run timing (no HALT): `start` sampled at edge t. Instruction k appears on `cpu_instr` during cycle t+1+k. `done` is high during cycle t+1+`prog_len`.
- `busy` is high exactly during the issue cycles.
- Throughput: one instruction per cycle, no bubbles.
- `prog_len` updates the cycle after the handshake. A full buffer is reflected in `wr_ready` the cycle after the DEPTH-th write.

## Configuration
- `CPU8_SEQ_LOOP_EN` defined:
  - The `loop_count` input exists and is latched at `start`.
  - The program runs `loop_count+1` times back-to-back. After the last index, `pc` wraps to 0 with no gap cycle.
  - HALT or `abort` ends all remaining passes. `done` pulses once, after the final pass.
- Not defined: the port is absent and the program runs exactly once.

## Structure
- Package `cpu8_pkg` holds:
  - the opcode enum (`OP_NOP`..`OP_NOT`, `OP_HALT = 4'hF`);
  - the `seq_state_t` enum;
  - the constant `CPU8_NOP = 8'h00`.
- Sub-module `cpu8_prog_mem`: DEPTH x 8 register file with one synchronous write port and one combinational read port, no reset on its contents. The FSM, `pc` and handshake logic stay in the top module.

## Test plan
- Reset, then write 11, 23, 34, 42, 50, then `start`. Expect `cpu_instr` = 11, 23, 34, 42, 50 on five consecutive cycles with `cpu_valid` high, then `done` one cycle later. `prog_len` stays 5.
- Fill DEPTH=16 bytes while holding `wr_valid` for 18 cycles. Expect `wr_ready` to drop after the 16th write, `prog_len = 16`, and the extra bytes not stored.
- Load 11, F0, 23 and start. Expect only 11 issued, then `done`. 23 is never driven.
- `start` with an empty buffer. Expect `busy` never high and `done` at t+1.
- Load 4 bytes, start, assert `abort` during the second issue cycle. Expect `cpu_instr = 00` from the next cycle, no `done`, return to IDLE, and a rerun reissuing all 4 bytes.
- With `CPU8_SEQ_LOOP_EN`, `loop_count = 2`, program 11, 23: expect 11, 23, 11, 23, 11, 23 on six consecutive cycles, then a single `done`.

Source files
------------

// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared opcode and sequencer state types for the 8-bit accumulator CPU
package cpu8_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_NOT  = 4'h5,
    OP_HALT = 4'hF
  } opcode_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_state_t;
  localparam logic [7:0] CPU8_NOP = 8'h00;
endpackage

// File: rtl/cpu8_prog_mem.sv
// cpu8_prog_mem: DEPTH x 8 program buffer, synchronous write, combinational read, contents not reset
module cpu8_prog_mem #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // store one program byte per accepted handshake
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu8_prog_sequencer.sv
// cpu8_prog_sequencer: buffers a program and issues it to the CPU one byte per clock; CPU8_SEQ_LOOP_EN adds loop_count repeat passes
module cpu8_prog_sequencer
  import cpu8_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        clear,
  input  logic        start,
  input  logic        abort,
`ifdef CPU8_SEQ_LOOP_EN
  input  logic [3:0]  loop_count,
`endif
  output logic        busy,
  output logic        done,
  output logic [AW:0] prog_len,
  output logic [7:0]  cpu_instr,
  output logic        cpu_valid
);
  seq_state_t state;
  logic [AW-1:0] pc;
  logic [7:0] rd_data;
  logic we, last, halt, wrap;
  logic [AW:0] next_len;
  assign wr_ready = state == S_IDLE && prog_len != (AW+1)'(DEPTH);
  assign we = wr_valid && wr_ready && !clear;
  assign next_len = clear ? '0 : prog_len + (AW+1)'(we);
  assign last = {1'b0, pc} == prog_len - (AW+1)'(1);
  assign halt = rd_data[7:4] == OP_HALT;
  cpu8_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(prog_len[AW-1:0]),
    .wdata(wr_data),
    .raddr(pc),
    .rdata(rd_data)
  );
`ifdef CPU8_SEQ_LOOP_EN
  logic [3:0] passes;
  // extra passes still owed: latched at start, spent at each wrap back to index 0
  always_ff @(posedge clk)
    if (rst) passes <= '0;
    else if (state == S_IDLE && start) passes <= loop_count;
    else if (state == S_RUN && !abort && !halt && last && wrap) passes <= passes - 4'd1;
  assign wrap = passes != '0;
`else
  assign wrap = 1'b0;
`endif
  // sequencer FSM; every output is registered, so it trails the state by one cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      prog_len <= '0;
      pc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cpu_instr <= CPU8_NOP;
      cpu_valid <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      cpu_instr <= CPU8_NOP;
      cpu_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          prog_len <= next_len;
          if (start) begin
            pc <= '0;
            state <= next_len != '0 ? S_RUN : S_DONE;
          end
        end
        S_RUN:
          if (abort) state <= S_IDLE;
          else if (halt) state <= S_DONE;
          else begin
            busy <= 1'b1;
            cpu_instr <= rd_data;
            cpu_valid <= 1'b1;
            pc <= last ? '0 : pc + AW'(1);
            if (last && !wrap) state <= S_DONE;
          end
        default: begin
          done <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
endmodule
